// File: rtl/pipelined_alu.sv
// pipelined_alu: valid/ready ALU with registered result/flags and optional iterative shift-add multiplier.
// Optional feature macro: PIPELINED_ALU_MUL_EN. When it is defined, opcode 1010 runs a NUMBITS-cycle
// multiply. When it is undefined, 1010 is treated as an illegal opcode.
// Ports: clk, reset (async, active-high); in_valid/in_ready, A, B, opcode (input side);
//        out_valid/out_ready, result, carryout, overflow, zero, illegal (registered output side).
module pipelined_alu #(
    parameter  int NUMBITS = 16,
    localparam int SHW     = $clog2(NUMBITS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMBITS-1:0] A,
    input  logic [NUMBITS-1:0] B,
    input  logic [3:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMBITS-1:0] result,
    output logic               carryout,
    output logic               overflow,
    output logic               zero,
    output logic               illegal
);
    localparam logic [3:0] OP_ADDU = 4'h0, OP_ADDS = 4'h1, OP_SUBU = 4'h2, OP_SUBS = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4, OP_OR   = 4'h5, OP_XOR  = 4'h6, OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8, OP_SRA  = 4'h9, OP_SLT  = 4'hB, OP_SLTU = 4'hC;
    localparam int         MSB     = NUMBITS - 1;

    logic [SHW-1:0]     amt;
    logic [NUMBITS:0]   sum, diff, srl_w, sll_w, sra_w;
    logic [NUMBITS-1:0] alu_res;
    logic               alu_c, alu_v, alu_ill;
    logic               in_fire;

    // Shifts run one bit wider so the last bit shifted out lands in the extra bit
    // (and is naturally 0 for a zero amount).
    always_comb begin
        amt     = B[SHW-1:0];
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        srl_w   = {A, 1'b0} >> amt;
        sll_w   = {1'b0, A} << amt;
        sra_w   = $unsigned($signed({A, 1'b0}) >>> amt);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (opcode)
            OP_ADDU: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[NUMBITS];
            end
            OP_ADDS: begin
                alu_res = sum[MSB:0];
                alu_v   = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUBU: begin
                alu_res = diff[MSB:0];
                alu_c   = diff[NUMBITS];
            end
            OP_SUBS: begin
                alu_res = diff[MSB:0];
                alu_v   = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SRL: begin
                alu_res = srl_w[NUMBITS:1];
                alu_c   = srl_w[0];
            end
            OP_SLL: begin
                alu_res = sll_w[MSB:0];
                alu_c   = sll_w[NUMBITS];
            end
            OP_SRA: begin
                alu_res = sra_w[NUMBITS:1];
                alu_c   = sra_w[0];
            end
            OP_SLT:  alu_res = NUMBITS'($signed(A) < $signed(B));
            OP_SLTU: alu_res = NUMBITS'(A < B);
            default: alu_ill = 1'b1;
        endcase
    end

    assign in_fire = in_valid && in_ready;

`ifdef PIPELINED_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'hA;
    localparam int         CW     = $clog2(NUMBITS + 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t               state;
    logic [2*NUMBITS-1:0] mcand, acc, acc_nxt;
    logic [NUMBITS-1:0]   mplier;
    logic [CW-1:0]        cnt;
    logic                 is_mul;

    assign is_mul   = opcode == OP_MUL;
    assign acc_nxt  = mplier[0] ? acc + mcand : acc;
    assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (in_fire && !is_mul) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                carryout  <= alu_c;
                overflow  <= alu_v;
                zero      <= alu_res == '0;
                illegal   <= alu_ill;
            end
            if (in_fire && is_mul) begin
                mcand  <= {{NUMBITS{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
                cnt    <= CW'(NUMBITS);
                state  <= MUL;
            end
            if (state == MUL) begin
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                acc    <= acc_nxt;
                cnt    <= cnt - 1'b1;
                // The final step publishes the freshly accumulated product directly.
                if (cnt == CW'(1)) begin
                    state     <= IDLE;
                    out_valid <= 1'b1;
                    result    <= acc_nxt[MSB:0];
                    carryout  <= 1'b0;
                    overflow  <= |acc_nxt[2*NUMBITS-1:NUMBITS];
                    zero      <= acc_nxt[MSB:0] == '0;
                    illegal   <= 1'b0;
                end
            end
        end
    end
`else
    assign in_ready = (!out_valid || out_ready) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carryout  <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (in_fire) begin
                out_valid <= 1'b1;
                result    <= alu_res;
                carryout  <= alu_c;
                overflow  <= alu_v;
                zero      <= alu_res == '0;
                illegal   <= alu_ill;
            end
        end
    end
`endif
endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: table-driven and directed self-checking bench for pipelined_alu (NUMBITS=16).
module tb_pipelined_alu;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, carryout, overflow, zero, illegal;
    logic [15:0] A = '0, B = '0, result;
    logic [3:0]  opcode = '0;
    int          errors = 0, checks = 0;
    logic        mon_en = 1'b0;
    logic [15:0] got[$];

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, res;
        logic        c, v, z, ill;
    } vec_t;
    vec_t tbl[16];

    pipelined_alu #(.NUMBITS(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carryout(carryout), .overflow(overflow), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mon_en && out_valid && out_ready && !reset)
            got.push_back(result);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!in_ready && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) chk("send_in_ready_timeout", 32'(in_ready), 32'd1);
        opcode   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'h2, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'h3, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{4'h4, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'h5, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'h6, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4'h7, 16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'h8, 16'h0001, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'h9, 16'h8001, 16'h0001, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'hB, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{4'hC, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{4'hD, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{4'h7, 16'h0004, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{4'h1, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{4'h8, 16'h8001, 16'h0011, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'({carryout, overflow, zero, illegal}), 0);
        reset = 1'b0;
        #1;
        chk("rst_release_in_ready", 32'(in_ready), 1);

        // Single-cycle op table, back to back with out_ready high.
        for (int i = 0; i < 16; i++) begin
            send(tbl[i].op, tbl[i].a, tbl[i].b);
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_result", i), 32'(result), 32'(tbl[i].res));
            chk($sformatf("v%0d_carryout", i), 32'(carryout), 32'(tbl[i].c));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(tbl[i].v));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(tbl[i].z));
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
        end
        @(posedge clk);
        #1;
        chk("drain_out_valid", 32'(out_valid), 0);

        // Multiply 0x0100 * 0x0100.
        send(4'hA, 16'h0100, 16'h0100);
`ifdef PIPELINED_ALU_MUL_EN
        begin
            int n = 0;
            while (!out_valid && n < 40) begin
                chk($sformatf("mul_in_ready_c%0d", n), 32'(in_ready), 0);
                @(posedge clk);
                #1;
                n++;
            end
            chk("mul_latency", 32'(n), 16);
        end
        chk("mul_result", 32'(result), 0);
        chk("mul_overflow", 32'(overflow), 1);
        chk("mul_zero", 32'(zero), 1);
        chk("mul_carry_illegal", 32'({carryout, illegal}), 0);
`else
        chk("mul_out_valid", 32'(out_valid), 1);
        chk("mul_result", 32'(result), 0);
        chk("mul_zero", 32'(zero), 1);
        chk("mul_illegal", 32'(illegal), 1);
        chk("mul_overflow", 32'(overflow), 0);
`endif
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply aborts it.
        send(4'hA, 16'h0007, 16'h0009);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_flags", 32'({carryout, overflow, zero, illegal}), 0);
        chk("midrst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_release_in_ready", 32'(in_ready), 1);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_valid), 0);
        chk("midrst_result_late", 32'(result), 0);

        // Back-pressure: 4 XORs, out_ready low for 3 cycles after the first.
        mon_en    = 1'b1;
        out_ready = 1'b0;
        send(4'h6, 16'h1111, 16'h0101);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_result_c%0d", i), 32'(result), 32'h1010);
            chk($sformatf("bp_hold_valid_c%0d", i), 32'(out_valid), 1);
            chk($sformatf("bp_in_ready_c%0d", i), 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(4'h6, 16'h2222, 16'h0202);
        send(4'h6, 16'h3333, 16'h0303);
        send(4'h6, 16'h4444, 16'h0404);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("bp_count", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("bp_r0", 32'(got[0]), 32'h1010);
            chk("bp_r1", 32'(got[1]), 32'h2020);
            chk("bp_r2", 32'(got[2]), 32'h3030);
            chk("bp_r3", 32'(got[3]), 32'h4040);
        end
        chk("bp_drained", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_alu.md
# pipelined_alu

Parametrised, handshaked successor to the team's 16-bit registered ALU. It adds a valid/ready interface on both sides and a 4-bit opcode space with variable shifts, set-less-than and an iterative shift-add multiplier. Every op has registered result and flags. It sits between the decode stage and writeback; single-cycle ops complete in one cycle, multiply stalls the input.

## Interface
- NUMBITS, 16: operand/result width (>= 4).
- SHW, $clog2(NUMBITS): shift-amount width, derived; not overridden.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready at a clk edge.
- A  input  NUMBITS  operand A.
- B  input  NUMBITS  operand B; shifts use B[SHW-1:0] as the amount.
- opcode  input  4  operation select.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts; output retires when out_valid && out_ready.
- result  output  NUMBITS  registered result.
- carryout, overflow, zero, illegal  output  1 each  registered flags.

## Operation
- Opcodes and flags; zero = (result == 0) for every op, otherwise flags are 0 unless listed:
  - 0000 unsigned add: carryout = bit NUMBITS of the (NUMBITS+1)-bit sum.
  - 0001 signed add: overflow = (A[msb]==B[msb]) && (result[msb]!=A[msb]).
  - 0010 unsigned sub: carryout = borrow (A < B unsigned).
  - 0011 signed sub: overflow = (A[msb]!=B[msb]) && (result[msb]!=A[msb]).
  - 0100 AND, 0101 OR, 0110 XOR.
  - 0111 SRL, 1000 SLL, 1001 SRA by B[SHW-1:0]: carryout = last bit shifted out, 0 when the amount is 0.
  - 1010 MUL: result = low NUMBITS of unsigned A*B; overflow = (high half != 0).
  - 1011 SLT signed, 1100 SLTU: result = {0…,1} if A < B, else 0.
  - 1101–1111: result 0, zero 1, illegal 1; completes with single-cycle latency.
- FSM states:
  - IDLE: accepts new work. A non-MUL op loads the output register directly. MUL loads the multiplicand, multiplier, 2*NUMBITS accumulator and count = NUMBITS, then moves to MUL.
  - MUL: one shift-add step per cycle. After the last step, it loads the output register, sets out_valid and returns to IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !reset.
- Output register holds result and flags stable while out_valid && !out_ready.

## Timing
- Reset (async, immediate) sets:
  - state = IDLE;
  - result = 0; carryout, overflow, zero and illegal = 0;
  - out_valid = 0; multiplier datapath cleared.
- Reset asserted mid-MUL aborts the operation; the result is never presented. in_ready is 1 on the first cycle after deassertion.
- Single-cycle ops: accepted at edge k, so out_valid = 1 and the result is valid after edge k.
- MUL: accepted at edge k, so in_ready = 0 during cycles k..k+NUMBITS-1, and out_valid rises after edge k+NUMBITS.
- Retire and accept on the same edge (out_valid && out_ready && in_valid) is legal and gives back-to-back throughput of 1 op/cycle for non-MUL ops.
- If out_valid && out_ready with no new input, out_valid falls after that edge.
- A MUL is accepted only when the output register is empty or draining, so out_valid is 0 for its whole duration.
- Arithmetic is computed at NUMBITS+1 width for add/sub; the multiplier accumulator is 2*NUMBITS wide.

## Configuration
- PIPELINED_ALU_MUL_EN defined: opcode 1010 performs the iterative multiply as above.
- PIPELINED_ALU_MUL_EN undefined: the MUL state and datapath are not built, and 1010 behaves as an illegal opcode (result 0, zero 1, illegal 1, latency 1). in_ready then depends only on output-register occupancy.

## Test plan
- Reset mid-MUL (A=7, B=9, reset at cycle 5, NUMBITS=16): out_valid stays 0, all outputs 0; in_ready = 1 on the cycle after release.
- Adds, NUMBITS=16:
  - unsigned add 0xFFFF+0x0001: result 0x0000, carryout 1, zero 1;
  - signed add 0x7FFF+0x0001: result 0x8000, overflow 1.
- Subtracts:
  - unsigned sub 0x0003-0x0005: result 0xFFFE, carryout 1;
  - signed sub 0x8000-0x0001: result 0x7FFF, overflow 1.
- Shifts and SLT:
  - SRA 0x8001 by 1: result 0xC000, carryout 1;
  - SLL 0x0001 by 0: result 0x0001, carryout 0;
  - SLT 0xFFFF vs 0x0001: result 1; SLTU of the same operands: result 0.
- MUL:
  - 0x0100*0x0100: result 0x0000, overflow 1, zero 1, out_valid exactly 16 cycles after acceptance;
  - with the macro undefined, the same stimulus gives illegal 1 after 1 cycle.
- Back-pressure, 4 back-to-back XORs with out_ready low for 3 cycles: the first result is held stable, in_ready = 0 while full, and all 4 results emerge in order with no loss or duplication.
